prio_encoder_rr: RTL and testbench
==================================

Name: prio_encoder_rr

Overview:
- Parametrised, registered successor to the 4-to-2 combinational encoder.
- Captures request pulses on N_REQ lines into a sticky pending register and presents one binary index at a time to a consumer over a valid/ready handshake.
- Arbitration is fixed-priority or round-robin, selected by parameter.
- Sits between lab request sources (switches, debounced buttons, timers) and a single sequential consumer such as a display or counter controller.

Parameters:
- N_REQ, 4: number of request lines, ≥2.
- RR_MODE, 0: 0 = fixed priority (highest index wins); 1 = round-robin.
- IDX_W, $clog2(N_REQ): index width, minimum 1. Derived localparam; never overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush of all pending and presented requests.
- req_in  in  N_REQ  request lines, level-sampled each rising edge.
- enc_out  out  IDX_W  index of presented request.
- enc_valid  out  1  enc_out holds a request awaiting acceptance.
- enc_ready  in  1  consumer accepts when high together with enc_valid.
- pending  out  N_REQ  captured requests not yet presented; excludes the presented one.
- overrun  out  N_REQ  one-cycle pulse per bit: request lost because that bit was already pending or presented.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pending, enc_out, enc_valid and overrun are all 0.
  - Round-robin pointer last_idx = N_REQ-1, so index 0 has top priority first.
- Handshake: a transfer occurs at a rising edge where enc_valid=1 and enc_ready=1.
  - While enc_valid=1 and enc_ready=0, enc_out and enc_valid are held stable.
  - enc_ready while enc_valid=0 has no effect.
- Output slot states:
  - EMPTY (enc_valid=0) and FULL (enc_valid=1).
  - The slot loads at any edge where it is EMPTY or a transfer occurs.
- Candidate set at a load edge = pending | req_in.
  - If the candidate set is nonzero, the winner is loaded into enc_out, enc_valid=1, and the winner bit is removed from pending.
  - If the candidate set is zero, enc_valid goes to 0 and enc_out holds its last value.
- Latency:
  - A request sampled at edge k with an EMPTY slot gives enc_valid=1 after edge k.
  - Back-to-back transfers are possible: one index per cycle at full throughput.
- Fixed priority (RR_MODE=0): the highest set index wins.
- Round-robin (RR_MODE=1):
  - Search starts at last_idx+1, wrapping modulo N_REQ; the first set bit wins.
  - last_idx updates to the winner on every load.
- Capture at each edge for bits not loaded into the slot: pending |= req_in.
- Overrun: overrun[i]=1 for exactly the cycle after an edge where req_in[i]=1 and either:
  - pending[i] was already 1, or
  - i is presented in a slot that is not being transferred and reloaded that edge.
- Same-edge re-request:
  - If req_in[i]=1 on the edge where presented index i transfers, the new request is captured (pending or re-presented).
  - No overrun is flagged in this case.
- clr=1 at an edge:
  - pending=0, enc_valid=0, last_idx=N_REQ-1, overrun=0.
  - req_in is ignored that edge.
  - Any transfer on that edge counts as completed.
  - rst_n overrides clr.
- Reset mid-transfer: state is cleared immediately (asynchronous), with no partial handshake.
- Non-power-of-two N_REQ: enc_out never exceeds N_REQ-1; unused codes are never produced.

Test Plan:
1. Reset/idle: rst_n low for 3 cycles, req_in=0 → all outputs 0; release rst_n → enc_valid stays 0.
2. Fixed priority, N_REQ=4, RR_MODE=0, enc_ready=0:
   - Stimulus: req_in=4'b1111 for one cycle.
   - Response: after edge, enc_out=3, enc_valid=1, pending=4'b0111.
   - Then enc_ready=1 for 3 cycles → enc_out sequence 2, 1, 0 with pending emptying; enc_valid drops after the 4th transfer.
3. Round-robin, RR_MODE=1, enc_ready=1 held:
   - Stimulus: req_in=4'b1111 held continuously.
   - Response: enc_out sequence 0, 1, 2, 3, 0, 1 on consecutive cycles; enc_valid constant 1.
4. Stall and overrun:
   - Stimulus: req_in=4'b0100 for one cycle, enc_ready=0, then req_in=4'b0100 again.
   - Response: enc_out=2 held stable; overrun=4'b0100 for one cycle; pending stays 0.
5. Same-edge re-request: enc_out=1 presented; req_in=4'b0010 on the same edge as enc_ready=1 → enc_out=1 remains valid next cycle, overrun=0.
6. clr mid-operation and reset: pending=4'b1010 with slot FULL, assert clr one cycle while req_in=4'b0001 → pending=0, enc_valid=0; pulse rst_n low mid-cycle → outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/prio_encoder_rr.sv
`timescale 1ns/1ps
// Registered request encoder: sticky pending capture plus one-slot valid/ready
// output, with fixed-priority (highest index) or round-robin arbitration.
//
// state   | meaning
// S_EMPTY | no index presented, enc_valid low
// S_FULL  | enc_out presented, waiting for enc_ready
module prio_encoder_rr #(
  parameter int N_REQ = 4,
  parameter bit RR_MODE = 1'b0,
  localparam int IDX_W = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [N_REQ-1:0] req_in,
  output logic [IDX_W-1:0] enc_out,
  output logic             enc_valid,
  input  logic             enc_ready,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] overrun
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} slot_t;

  slot_t            state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [N_REQ-1:0] ovr_q, ovr_d;
  logic [N_REQ-1:0] cand, win_oh, pres_oh;
  logic             xfer, load, win_any;

  assign xfer    = (state_q == S_FULL) && enc_ready;
  assign load    = (state_q == S_EMPTY) || xfer;
  assign cand    = pend_q | req_in;
  assign win_any = |cand;
  assign win_oh  = N_REQ'(1) << win_idx;
  // The presented bit only blocks capture while the slot actually holds it.
  assign pres_oh = (state_q == S_FULL) ? (N_REQ'(1) << idx_q) : '0;

  // Winner select: highest set index, or first set bit after last_q (wrapping).
  always_comb begin
    logic [IDX_W-1:0] k;
    logic             hit;
    win_idx = '0;
    k       = '0;
    hit     = 1'b0;
    if (RR_MODE) begin
      for (int off = 1; off <= N_REQ; off++) begin
        k = IDX_W'((int'(last_q) + off) % N_REQ);
        if (!hit && cand[k]) begin
          win_idx = k;
          hit     = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (cand[IDX_W'(i)]) win_idx = IDX_W'(i);
      end
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // Slot next state: reload on empty or transfer, flush on clr.
  always_comb begin
    state_d = state_q;
    if (clr)       state_d = S_EMPTY;
    else if (load) state_d = win_any ? S_FULL : S_EMPTY;
  end

  // Slot outputs.
  always_comb begin
    enc_valid = (state_q == S_FULL);
    enc_out   = idx_q;
    pending   = pend_q;
    overrun   = ovr_q;
  end

  // Datapath next values: pending capture, loaded index, RR pointer, overrun.
  always_comb begin
    pend_d = pend_q;
    idx_d  = idx_q;
    last_d = last_q;
    ovr_d  = '0;
    if (clr) begin
      pend_d = '0;
      last_d = IDX_W'(N_REQ - 1);
    end else if (load) begin
      // A re-request of the index being transferred is legitimately captured.
      ovr_d = req_in & pend_q;
      if (win_any) begin
        idx_d  = win_idx;
        last_d = win_idx;
        pend_d = cand & ~win_oh;
      end else begin
        pend_d = cand;
      end
    end else begin
      ovr_d  = req_in & (pend_q | pres_oh);
      pend_d = pend_q | (req_in & ~pres_oh);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      idx_q  <= '0;
      last_q <= IDX_W'(N_REQ - 1);
      ovr_q  <= '0;
    end else begin
      pend_q <= pend_d;
      idx_q  <= idx_d;
      last_q <= last_d;
      ovr_q  <= ovr_d;
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
`timescale 1ns/1ps
// Directed bench: fixed-priority (N=4), round-robin (N=4) and round-robin (N=3)
// instances share one stimulus bus.
module tb_prio_encoder_rr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] req = '0;
  logic       rdy = 1'b0;

  logic [1:0] fp_out;
  logic       fp_val;
  logic [3:0] fp_pend, fp_ovr;
  logic [1:0] rr_out;
  logic       rr_val;
  logic [3:0] rr_pend, rr_ovr;
  logic [1:0] n3_out;
  logic       n3_val;
  logic [2:0] n3_pend, n3_ovr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  prio_encoder_rr #(.N_REQ(4), .RR_MODE(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req_in(req),
    .enc_out(fp_out), .enc_valid(fp_val), .enc_ready(rdy),
    .pending(fp_pend), .overrun(fp_ovr));

  prio_encoder_rr #(.N_REQ(4), .RR_MODE(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req_in(req),
    .enc_out(rr_out), .enc_valid(rr_val), .enc_ready(rdy),
    .pending(rr_pend), .overrun(rr_ovr));

  prio_encoder_rr #(.N_REQ(3), .RR_MODE(1'b1)) dut_n3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req_in(req[2:0]),
    .enc_out(n3_out), .enc_valid(n3_val), .enc_ready(rdy),
    .pending(n3_pend), .overrun(n3_ovr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr = 1'b0; req = '0; rdy = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; req = '0; rdy = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (fp_val !== 1'b0) begin n_errors++; $display("FAIL rst_valid got %b exp 0", fp_val); end
    n_checks++; if (fp_out !== 2'd0) begin n_errors++; $display("FAIL rst_out got %0d exp 0", fp_out); end
    n_checks++; if (fp_pend !== 4'b0000) begin n_errors++; $display("FAIL rst_pending got %b exp 0000", fp_pend); end
    n_checks++; if (fp_ovr !== 4'b0000) begin n_errors++; $display("FAIL rst_overrun got %b exp 0000", fp_ovr); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (fp_val !== 1'b0 || rr_val !== 1'b0) begin n_errors++; $display("FAIL idle_valid got %b%b exp 00", fp_val, rr_val); end
  endtask

  task automatic test_fixed_priority();
    logic [1:0] exp_out [3];
    logic [3:0] exp_pend [3];
    exp_out  = '{2'd2, 2'd1, 2'd0};
    exp_pend = '{4'b0011, 4'b0001, 4'b0000};
    do_reset();
    rdy = 1'b0; req = 4'b1111;
    tick();
    req = 4'b0000;
    n_checks++; if (fp_out !== 2'd3 || fp_val !== 1'b1) begin n_errors++; $display("FAIL fp_first got out=%0d v=%b exp out=3 v=1", fp_out, fp_val); end
    n_checks++; if (fp_pend !== 4'b0111) begin n_errors++; $display("FAIL fp_first_pending got %b exp 0111", fp_pend); end
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (fp_out !== exp_out[i] || fp_val !== 1'b1 || fp_pend !== exp_pend[i]) begin
        n_errors++;
        $display("FAIL fp_seq%0d got out=%0d v=%b p=%b exp out=%0d v=1 p=%b", i, fp_out, fp_val, fp_pend, exp_out[i], exp_pend[i]);
      end
    end
    tick();
    n_checks++; if (fp_val !== 1'b0 || fp_out !== 2'd0) begin n_errors++; $display("FAIL fp_drain got v=%b out=%0d exp v=0 out=0", fp_val, fp_out); end
    rdy = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rr [6];
    logic [1:0] exp_n3 [6];
    exp_rr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_n3 = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    do_reset();
    rdy = 1'b1; req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (rr_out !== exp_rr[i] || rr_val !== 1'b1) begin
        n_errors++;
        $display("FAIL rr_seq%0d got out=%0d v=%b exp out=%0d v=1", i, rr_out, rr_val, exp_rr[i]);
      end
      n_checks++;
      if (n3_out !== exp_n3[i] || n3_val !== 1'b1) begin
        n_errors++;
        $display("FAIL n3_seq%0d got out=%0d v=%b exp out=%0d v=1", i, n3_out, n3_val, exp_n3[i]);
      end
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++; if (rr_val !== 1'b0 || rr_pend !== 4'b0000) begin n_errors++; $display("FAIL rr_clr got v=%b p=%b exp v=0 p=0000", rr_val, rr_pend); end
    tick();
    n_checks++; if (rr_out !== 2'd0 || n3_out !== 2'd0) begin n_errors++; $display("FAIL rr_ptr_after_clr got rr=%0d n3=%0d exp 0 0", rr_out, n3_out); end
    req = 4'b0000; rdy = 1'b0;
  endtask

  task automatic test_stall_overrun();
    do_reset();
    rdy = 1'b0; req = 4'b0100;
    tick();
    n_checks++; if (fp_out !== 2'd2 || fp_val !== 1'b1 || fp_ovr !== 4'b0000) begin n_errors++; $display("FAIL st_load got out=%0d v=%b o=%b exp out=2 v=1 o=0000", fp_out, fp_val, fp_ovr); end
    tick();
    req = 4'b0000;
    n_checks++; if (fp_ovr !== 4'b0100) begin n_errors++; $display("FAIL st_overrun got %b exp 0100", fp_ovr); end
    n_checks++; if (fp_pend !== 4'b0000 || fp_out !== 2'd2 || fp_val !== 1'b1) begin n_errors++; $display("FAIL st_hold got p=%b out=%0d v=%b exp p=0000 out=2 v=1", fp_pend, fp_out, fp_val); end
    tick();
    n_checks++; if (fp_ovr !== 4'b0000 || fp_out !== 2'd2 || fp_val !== 1'b1) begin n_errors++; $display("FAIL st_pulse got o=%b out=%0d v=%b exp o=0000 out=2 v=1", fp_ovr, fp_out, fp_val); end
  endtask

  task automatic test_same_edge_rerequest();
    do_reset();
    rdy = 1'b0; req = 4'b0010;
    tick();
    n_checks++; if (fp_out !== 2'd1 || fp_val !== 1'b1) begin n_errors++; $display("FAIL se_load got out=%0d v=%b exp out=1 v=1", fp_out, fp_val); end
    rdy = 1'b1; req = 4'b0010;
    tick();
    rdy = 1'b0; req = 4'b0000;
    n_checks++; if (fp_out !== 2'd1 || fp_val !== 1'b1 || fp_ovr !== 4'b0000 || fp_pend !== 4'b0000) begin
      n_errors++; $display("FAIL se_rereq got out=%0d v=%b o=%b p=%b exp out=1 v=1 o=0000 p=0000", fp_out, fp_val, fp_ovr, fp_pend);
    end
  endtask

  task automatic test_clr_and_async_reset();
    do_reset();
    rdy = 1'b0; req = 4'b0100;
    tick();
    req = 4'b1010;
    tick();
    n_checks++; if (fp_pend !== 4'b1010 || fp_out !== 2'd2 || fp_val !== 1'b1) begin n_errors++; $display("FAIL clr_setup got p=%b out=%0d v=%b exp p=1010 out=2 v=1", fp_pend, fp_out, fp_val); end
    clr = 1'b1; req = 4'b0001;
    tick();
    clr = 1'b0; req = 4'b0000;
    n_checks++; if (fp_pend !== 4'b0000 || fp_val !== 1'b0 || fp_ovr !== 4'b0000) begin n_errors++; $display("FAIL clr_flush got p=%b v=%b o=%b exp p=0000 v=0 o=0000", fp_pend, fp_val, fp_ovr); end
    tick();
    n_checks++; if (fp_val !== 1'b0 || fp_pend !== 4'b0000) begin n_errors++; $display("FAIL clr_ignored_req got v=%b p=%b exp v=0 p=0000", fp_val, fp_pend); end
    req = 4'b1000;
    tick();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    n_checks++; if (fp_out !== 2'd3 || fp_val !== 1'b1 || fp_pend !== 4'b0100) begin n_errors++; $display("FAIL ar_setup got out=%0d v=%b p=%b exp out=3 v=1 p=0100", fp_out, fp_val, fp_pend); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (fp_out !== 2'd0 || fp_val !== 1'b0 || fp_pend !== 4'b0000 || fp_ovr !== 4'b0000) begin
      n_errors++; $display("FAIL ar_async got out=%0d v=%b p=%b o=%b exp all 0", fp_out, fp_val, fp_pend, fp_ovr);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (fp_val !== 1'b0) begin n_errors++; $display("FAIL ar_release got v=%b exp 0", fp_val); end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_stall_overrun();
    test_same_edge_rerequest();
    test_clr_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
